// File: rtl/fifo_wr_arb_if.sv
// Requester streams plus FIFO write port shared by the write arbiter.
interface fifo_wr_arb_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic [ID_WIDTH-1:0]           fifo_wr_id;
  logic                          fifo_full;
  logic                          busy;

  // Producer/FIFO side: drives requests and the full flag.
  modport master (
    output req_valid, req_last, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input logic          clk,
  input logic          reset,
  fifo_wr_arb_if.slave bus
);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  owner_q, owner_d;
  logic [ID_WIDTH-1:0]  last_winner_q, last_winner_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  beat;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found &&
          bus.req_valid[ID_WIDTH'((32'(last_winner_q) + i) % NUM_REQ)]) begin
        pick_found = 1'b1;
        pick_idx   = ID_WIDTH'((32'(last_winner_q) + i) % NUM_REQ);
      end
    end
  end

  // Select the owner's stream signals.
  always_comb begin
    owner_valid = bus.req_valid[owner_q];
    owner_last  = bus.req_last[owner_q];
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_WIDTH'(i)) begin
        owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and write-port outputs; a full FIFO stalls but never releases.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_winner_d    = last_winner_q;
    beat_cnt_d       = beat_cnt_q;
    beat             = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    bus.fifo_wr_id   = '0;
    bus.busy         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        bus.busy               = 1'b1;
        bus.req_ready[owner_q] = !bus.fifo_full;
        beat                   = owner_valid && !bus.fifo_full;
        if (beat) begin
          bus.fifo_wr_en   = 1'b1;
          bus.fifo_wr_data = owner_data;
          bus.fifo_wr_id   = owner_q;
          beat_cnt_d       = beat_cnt_q + CNT_WIDTH'(1);
          if (owner_last || (beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1))) begin
            state_d       = IDLE;
            last_winner_d = owner_q;
          end
        end else if (!owner_valid) begin
          state_d       = IDLE;
          last_winner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      last_winner_q <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
module tb_fifo_wr_arb;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fifo_wr_arb_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

  fifo_wr_arb #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    bus.req_data[i*32 +: 32] = v;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
  endtask

  // Leaves the DUT in IDLE at #1 after the reset edge with reset released.
  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.req_valid = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.fifo_wr_data); end
    n_cmp++; if (bus.fifo_wr_id !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d want 0", bus.fifo_wr_id); end
    tick();
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_burst();
    bus.req_valid = 4'b0001;
    set_data(0, 32'hA0);
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_arb_cycle wr_en got %b want 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL single_arb_cycle ready got %b want 0000", bus.req_ready); end
    for (int b = 0; b < 3; b++) begin
      tick();
      set_data(0, 32'hA0 + 32'(b));
      bus.req_last = (b == 2) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL single_beat%0d wr_en got %b want 1", b, bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_wr_id !== 2'd0) begin n_err++; $display("FAIL single_beat%0d id got %0d want 0", b, bus.fifo_wr_id); end
      n_cmp++; if (bus.fifo_wr_data !== 32'hA0 + 32'(b)) begin n_err++; $display("FAIL single_beat%0d data got %h want %h", b, bus.fifo_wr_data, 32'hA0 + 32'(b)); end
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_release busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL single_release wr_en got %b want 0", bus.fifo_wr_en); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    logic       exp_en;
    apply_reset();
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, 32'hB0 + 32'(i));
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_en = (c % 2) == 1;
      exp_id = exp_en ? 2'((c / 2) % 4) : 2'd0;
      n_cmp++; if (bus.fifo_wr_en !== exp_en) begin n_err++; $display("FAIL rr_cycle%0d wr_en got %b want %b", c, bus.fifo_wr_en, exp_en); end
      n_cmp++; if (bus.fifo_wr_id !== exp_id) begin n_err++; $display("FAIL rr_cycle%0d id got %0d want %0d", c, bus.fifo_wr_id, exp_id); end
      if (exp_en) begin
        n_cmp++; if (bus.fifo_wr_data !== 32'hB0 + 32'(exp_id)) begin n_err++; $display("FAIL rr_cycle%0d data got %h want %h", c, bus.fifo_wr_data, 32'hB0 + 32'(exp_id)); end
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_max_burst();
    logic        exp_en [9]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  exp_id [9]   = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2};
    logic [31:0] exp_data [9] = '{32'h0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'h0, 32'hD0, 32'h0, 32'hC4};
    logic [31:0] d2;
    apply_reset();
    d2 = 32'hC0;
    bus.req_valid = 4'b1100;
    bus.req_last  = 4'b1000;
    set_data(2, d2);
    set_data(3, 32'hD0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.fifo_wr_en !== exp_en[c]) begin n_err++; $display("FAIL burst_cycle%0d wr_en got %b want %b", c, bus.fifo_wr_en, exp_en[c]); end
      n_cmp++; if (bus.fifo_wr_id !== exp_id[c]) begin n_err++; $display("FAIL burst_cycle%0d id got %0d want %0d", c, bus.fifo_wr_id, exp_id[c]); end
      n_cmp++; if (bus.fifo_wr_data !== exp_data[c]) begin n_err++; $display("FAIL burst_cycle%0d data got %h want %h", c, bus.fifo_wr_data, exp_data[c]); end
      if (c == 6) begin
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL burst_r3_ready got %b want 1000", bus.req_ready); end
      end
      if (c == 5) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL burst_gap_busy got %b want 0", bus.busy); end
      end
      if (exp_en[c] && exp_id[c] == 2'd2) d2 = d2 + 32'd1;
      tick();
      set_data(2, d2);
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    apply_reset();
    bus.req_valid = 4'b0010;
    set_data(1, 32'hE0);
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_arb wr_en got %b want 0", bus.fifo_wr_en); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_data !== 32'hE0) begin n_err++; $display("FAIL full_beat0 data got %h want e0", bus.fifo_wr_data); end
    tick();
    set_data(1, 32'hE1);
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL full_stall%0d ready got %b want 0000", k, bus.req_ready); end
      n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_stall%0d wr_en got %b want 0", k, bus.fifo_wr_en); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL full_stall%0d busy got %b want 1", k, bus.busy); end
      tick();
      if (k == 4) bus.fifo_full = 1'b0;
    end
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL full_resume%0d wr_en got %b want 1", b, bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_wr_data !== 32'hE0 + 32'(b)) begin n_err++; $display("FAIL full_resume%0d data got %h want %h", b, bus.fifo_wr_data, 32'hE0 + 32'(b)); end
      n_cmp++; if (bus.fifo_wr_id !== 2'd1) begin n_err++; $display("FAIL full_resume%0d id got %0d want 1", b, bus.fifo_wr_id); end
      tick();
      set_data(1, 32'hE0 + 32'(b + 1));
    end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL full_release busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL full_release wr_en got %b want 0", bus.fifo_wr_en); end
    clear_inputs();
    tick();
  endtask

  task automatic test_bubble_release();
    apply_reset();
    bus.req_valid = 4'b0011;
    bus.req_last  = 4'b0010;
    set_data(0, 32'hF0);
    set_data(1, 32'h51);
    tick();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      n_cmp++; if (bus.fifo_wr_data !== 32'hF0 + 32'(b)) begin n_err++; $display("FAIL bubble_beat%0d data got %h want %h", b, bus.fifo_wr_data, 32'hF0 + 32'(b)); end
      tick();
      set_data(0, 32'hF1);
    end
    bus.req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL bubble_drop wr_en got %b want 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL bubble_drop busy got %b want 1", bus.busy); end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bubble_drop ready got %b want 0001", bus.req_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bubble_idle busy got %b want 0", bus.busy); end
    tick();
    bus.req_valid = 4'b0011;
    set_data(0, 32'hF2);
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_id !== 2'd1) begin n_err++; $display("FAIL bubble_r1 id got %0d want 1", bus.fifo_wr_id); end
    n_cmp++; if (bus.fifo_wr_data !== 32'h51) begin n_err++; $display("FAIL bubble_r1 data got %h want 51", bus.fifo_wr_data); end
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL bubble_r1 ready got %b want 0010", bus.req_ready); end
    tick();
    tick();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_err++; $display("FAIL bubble_regrant%0d wr_en got %b want 1", b, bus.fifo_wr_en); end
      n_cmp++; if (bus.fifo_wr_id !== 2'd0) begin n_err++; $display("FAIL bubble_regrant%0d id got %0d want 0", b, bus.fifo_wr_id); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL bubble_cnt_restart busy got %b want 0", bus.busy); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.req_valid = 4'b1000;
    set_data(3, 32'h30);
    set_data(0, 32'h40);
    tick();
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_id !== 2'd3) begin n_err++; $display("FAIL rstmid_beat1 id got %0d want 3", bus.fifo_wr_id); end
    tick();
    set_data(3, 32'h31);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_data !== 32'h31) begin n_err++; $display("FAIL rstmid_beat2 data got %h want 31", bus.fifo_wr_data); end
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_after wr_en got %b want 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_after ready got %b want 0000", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_data !== 32'h0) begin n_err++; $display("FAIL rstmid_after data got %h want 0", bus.fifo_wr_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (bus.fifo_wr_id !== 2'd0) begin n_err++; $display("FAIL rstmid_first_winner id got %0d want 0", bus.fifo_wr_id); end
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_first_winner ready got %b want 0001", bus.req_ready); end
    n_cmp++; if (bus.fifo_wr_data !== 32'h40) begin n_err++; $display("FAIL rstmid_first_winner data got %h want 40", bus.fifo_wr_data); end
    clear_inputs();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_max_burst();
    test_fifo_full();
    test_bubble_release();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- Each producer presents a valid/ready/last stream. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and forwards accepted beats onto the FIFO write port, tagged with the source index.
- It sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per beat; matches the FIFO data width.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..256).
- ID_WIDTH, $clog2(NUM_REQ), width of the source index.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accept; one-hot or zero.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_WIDTH  FIFO write payload.
- fifo_wr_id  out  ID_WIDTH  source index of the current beat.
- fifo_full  in  1  FIFO full flag.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE, owner = 0, beat_cnt = 0.
  - last_winner = NUM_REQ-1, so requester 0 has first priority after reset.
  - All outputs 0: req_ready, fifo_wr_en, fifo_wr_data, fifo_wr_id, busy.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - When any req_valid bit is set, select the first set bit searching upward from last_winner+1 with wrap modulo NUM_REQ.
  - Register the selection as owner, clear beat_cnt, go to GRANT.
  - Arbitration costs exactly one cycle; no beat is accepted in IDLE.
- GRANT:
  - busy = 1.
  - req_ready[owner] = !fifo_full; all other req_ready bits = 0.
  - A beat occurs when req_valid[owner] && req_ready[owner].
  - fifo_wr_en = beat (combinational, same cycle).
  - fifo_wr_data = req_data slice of owner.
  - fifo_wr_id = owner.
  - fifo_wr_data and fifo_wr_id are driven to 0 when no beat occurs.
  - beat_cnt increments on each beat.
- Release from GRANT to IDLE, with last_winner <= owner, on any of:
  - a beat with req_last[owner] = 1;
  - a beat when beat_cnt == MAX_BURST-1 (forced rotation; req_last ignored);
  - req_valid[owner] = 0 in any GRANT cycle (bubble release, no beat).
- The grant is always held while req_valid[owner] = 1 and fifo_full = 1. There is no timeout. A full FIFO never causes release.
- fifo_wr_en is never asserted while fifo_full = 1. The arbiter therefore never relies on the FIFO's internal overflow guard.
- Back-to-back bursts:
  - Minimum one IDLE cycle between grants.
  - Peak throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness:
  - With all NUM_REQ requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
  - No requester waits more than (NUM_REQ-1) grants.
- Single active requester:
  - Is re-granted after one IDLE cycle.
  - last_winner does not block it.
- Non-owner req_valid or req_last changes during GRANT have no effect.
- Reset asserted mid-burst:
  - Next cycle returns to IDLE with all outputs 0.
  - Any partially transferred burst is abandoned. Requesters must re-send it.
- beat_cnt width is $clog2(MAX_BURST+1). beat_cnt must not wrap within a grant.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-beat burst (data 0xA0..0xA2, last on beat 3) -> grant after 1 cycle; fifo_wr_en high 3 consecutive cycles; fifo_wr_id=0; data 0xA0,0xA1,0xA2; busy drops the cycle after the last beat.
- All 4 requesters valid continuously, each burst 1 beat with last=1 -> fifo_wr_id sequence 0,1,2,3,0,1,2,3; one write every 2 cycles.
- Requester 2 streams 10 beats, last=0 throughout, MAX_BURST=4, requester 3 also valid -> requester 2 writes 4 beats; requester 3 gets the next grant; requester 2 resumes after that.
- fifo_full asserted for 5 cycles in the middle of the owner's burst -> req_ready[owner]=0 and fifo_wr_en=0 for all 5 cycles; grant held; transfer resumes in the first cycle fifo_full=0; no beat lost or duplicated.
- Owner drops req_valid mid-burst after 2 beats, requester 1 pending -> release in the same cycle; requester 1 granted after the IDLE cycle; beat_cnt restarts at 0.
- Reset asserted during beat 2 of a 4-beat burst from requester 3 -> following cycle all outputs 0, state IDLE; with all requesters valid after reset, requester 0 wins first.
